// File: rtl/lvds_video_pkg.sv
// Shared definitions for the LVDS video receiver: word bit positions, FSM states, counter width.
package lvds_video_pkg;

    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Lane 2: {B2,B3,B4,B5,HS,VS,DE}
    localparam int BIT_B2 = 20;
    localparam int BIT_B3 = 19;
    localparam int BIT_B4 = 18;
    localparam int BIT_B5 = 17;
    localparam int BIT_HS = 16;
    localparam int BIT_VS = 15;
    localparam int BIT_DE = 14;
    // Lane 1: {G1,G2,G3,G4,G5,B0,B1}
    localparam int BIT_G1 = 13;
    localparam int BIT_G2 = 12;
    localparam int BIT_G3 = 11;
    localparam int BIT_G4 = 10;
    localparam int BIT_G5 = 9;
    localparam int BIT_B0 = 8;
    localparam int BIT_B1 = 7;
    // Lane 0: {R0,R1,R2,R3,R4,R5,G0}
    localparam int BIT_R0 = 6;
    localparam int BIT_R1 = 5;
    localparam int BIT_R2 = 4;
    localparam int BIT_R3 = 3;
    localparam int BIT_R4 = 2;
    localparam int BIT_R5 = 1;
    localparam int BIT_G0 = 0;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } rx_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/lvds_word_unpack.sv
// Combinational unpacking of one 21-bit deserialized 7:1 LVDS word into colour and sync fields.
module lvds_word_unpack
    import lvds_video_pkg::*;
(
    input  logic [20:0] word,
    output logic [5:0]  red,
    output logic [5:0]  green,
    output logic [5:0]  blue,
    output logic        hs,
    output logic        vs,
    output logic        de
);

    assign red   = {word[BIT_R5], word[BIT_R4], word[BIT_R3], word[BIT_R2], word[BIT_R1], word[BIT_R0]};
    assign green = {word[BIT_G5], word[BIT_G4], word[BIT_G3], word[BIT_G2], word[BIT_G1], word[BIT_G0]};
    assign blue  = {word[BIT_B5], word[BIT_B4], word[BIT_B3], word[BIT_B2], word[BIT_B1], word[BIT_B0]};
    assign hs    = word[BIT_HS];
    assign vs    = word[BIT_VS];
    assign de    = word[BIT_DE];

endmodule

// File: rtl/lvds_video_rx.sv
// LVDS video receiver: registers unpacked pixels, tracks position, measures frame timing and locks.
module lvds_video_rx
    import lvds_video_pkg::*;
#(
    parameter int EXP_H_ACTIVE = 1366,
    parameter int EXP_V_ACTIVE = 768,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [20:0]      in_data,
    output logic             pix_valid,
    output logic [5:0]       pix_r,
    output logic [5:0]       pix_g,
    output logic [5:0]       pix_b,
    output logic             pix_hs,
    output logic             pix_vs,
    output logic             pix_de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             sof,
    output logic             eol,
    output logic [CNT_W-1:0] meas_h_active,
    output logic [CNT_W-1:0] meas_v_active,
    output logic [CNT_W-1:0] meas_h_total,
    output logic [CNT_W-1:0] meas_v_total,
    output logic             locked,
    output logic             timing_err
);

    localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_H_ACTIVE);
    localparam logic [CNT_W-1:0] EXP_V    = CNT_W'(EXP_V_ACTIVE);
    localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_FRAMES);

    logic [5:0] w_r, w_g, w_b;
    logic       w_hs, w_vs, w_de;
    logic       prev_hs, prev_vs, prev_de;
    logic       frame_start, line_start, line_end, hs_rise;

    logic [CNT_W-1:0] h_run, h_tot_cnt, v_act_cnt, v_tot_cnt;
    logic [CNT_W-1:0] last_h_active, last_h_total;
    logic             seen_frame;

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] good_cnt, good_next;
    logic             err_next, frame_ok, line_bad;

    lvds_word_unpack u_unpack (
        .word  (in_data),
        .red   (w_r),
        .green (w_g),
        .blue  (w_b),
        .hs    (w_hs),
        .vs    (w_vs),
        .de    (w_de)
    );

    // Edges are judged between consecutive valid samples only, so idle cycles are invisible.
    assign frame_start = in_valid &  w_vs & ~prev_vs;
    assign line_start  = in_valid &  w_de & ~prev_de;
    assign line_end    = in_valid & ~w_de &  prev_de;
    assign hs_rise     = in_valid &  w_hs & ~prev_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_hs   <= 1'b1;
            prev_vs   <= 1'b1;
            prev_de   <= 1'b0;
            pix_valid <= 1'b0;
            pix_r     <= '0;
            pix_g     <= '0;
            pix_b     <= '0;
            pix_hs    <= 1'b1;
            pix_vs    <= 1'b1;
            pix_de    <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
        end else begin
            pix_valid <= in_valid;
            sof       <= frame_start;
            eol       <= line_end;
            if (in_valid) begin
                prev_hs <= w_hs;
                prev_vs <= w_vs;
                prev_de <= w_de;
                pix_r   <= w_r;
                pix_g   <= w_g;
                pix_b   <= w_b;
                pix_hs  <= w_hs;
                pix_vs  <= w_vs;
                pix_de  <= w_de;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_x <= '0;
            pix_y <= '0;
        end else begin
            if (line_start)
                pix_x <= '0;
            else if (in_valid && w_de)
                pix_x <= sat_inc(pix_x);

            if (frame_start)
                pix_y <= '0;
            else if (line_end)
                pix_y <= sat_inc(pix_y);
        end
    end

    // Per-line measurement: DE run length and valid-sample spacing of DE rising edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_run         <= '0;
            h_tot_cnt     <= '0;
            last_h_active <= '0;
            last_h_total  <= '0;
        end else begin
            if (line_start) begin
                h_run        <= CNT_W'(1);
                h_tot_cnt    <= CNT_W'(1);
                last_h_total <= h_tot_cnt;
            end else if (in_valid) begin
                if (w_de)
                    h_run <= sat_inc(h_run);
                h_tot_cnt <= sat_inc(h_tot_cnt);
            end
            if (line_end)
                last_h_active <= h_run;
        end
    end

    // A DE or HS edge on the frame-start sample already belongs to the new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_act_cnt     <= '0;
            v_tot_cnt     <= '0;
            seen_frame    <= 1'b0;
            meas_h_active <= '0;
            meas_v_active <= '0;
            meas_h_total  <= '0;
            meas_v_total  <= '0;
        end else if (frame_start) begin
            v_act_cnt  <= line_start ? CNT_W'(1) : '0;
            v_tot_cnt  <= hs_rise    ? CNT_W'(1) : '0;
            seen_frame <= 1'b1;
            if (seen_frame) begin
                meas_h_active <= last_h_active;
                meas_v_active <= v_act_cnt;
                meas_h_total  <= last_h_total;
                meas_v_total  <= v_tot_cnt;
            end
        end else begin
            if (line_start)
                v_act_cnt <= sat_inc(v_act_cnt);
            if (hs_rise)
                v_tot_cnt <= sat_inc(v_tot_cnt);
        end
    end

    assign frame_ok = (last_h_active == EXP_H) && (v_act_cnt == EXP_V);
    assign line_bad = line_end && (h_run != EXP_H);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_SEARCH;
            good_cnt   <= '0;
            timing_err <= 1'b0;
        end else begin
            state      <= state_next;
            good_cnt   <= good_next;
            timing_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (frame_start) begin
                    good_next  = '0;
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (frame_start) begin
                    if (frame_ok) begin
                        good_next = sat_inc(good_cnt);
                        if (sat_inc(good_cnt) >= LOCK_CNT)
                            state_next = ST_LOCKED;
                    end else begin
                        good_next = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if ((frame_start && !frame_ok) || line_bad) begin
                    err_next   = 1'b1;
                    state_next = ST_SEARCH;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_lvds_video_rx.sv
// Directed bench for lvds_video_rx on a scaled-down 16x6 raster (24 samples/line, 9 lines/frame).
module tb_lvds_video_rx;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int HT = 24;
    localparam int VT = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [20:0] in_data = '0;
    logic        pix_valid, pix_hs, pix_vs, pix_de, sof, eol, locked, timing_err;
    logic [5:0]  pix_r, pix_g, pix_b;
    logic [10:0] pix_x, pix_y, meas_h_active, meas_v_active, meas_h_total, meas_v_total;

    int checks = 0;
    int errors = 0;
    int gap_pct = 0;

    int   sof_cnt = 0, err_cnt = 0, eol_cnt = 0, xbad_cnt = 0, lenbad_cnt = 0;
    int   exp_x = 0, last_x = 0;
    logic run_active = 1'b0;
    logic lock_at_sof [0:63];

    lvds_video_rx #(
        .EXP_H_ACTIVE (H),
        .EXP_V_ACTIVE (V),
        .LOCK_FRAMES  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .pix_valid     (pix_valid),
        .pix_r         (pix_r),
        .pix_g         (pix_g),
        .pix_b         (pix_b),
        .pix_hs        (pix_hs),
        .pix_vs        (pix_vs),
        .pix_de        (pix_de),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .sof           (sof),
        .eol           (eol),
        .meas_h_active (meas_h_active),
        .meas_v_active (meas_v_active),
        .meas_h_total  (meas_h_total),
        .meas_v_total  (meas_v_total),
        .locked        (locked),
        .timing_err    (timing_err)
    );

    always #5 clk = ~clk;

    // Event recorder: strobes, lock state at each sof, and the expected pix_x run 0,1,2,...
    always @(negedge clk) begin
        if (!rst) begin
            run_active = 1'b0;
        end else begin
            if (sof) begin
                if (sof_cnt < 64)
                    lock_at_sof[sof_cnt] = locked;
                sof_cnt++;
            end
            if (timing_err)
                err_cnt++;
            if (pix_valid && pix_de) begin
                if (!run_active)
                    exp_x = 0;
                if (int'(pix_x) != exp_x)
                    xbad_cnt++;
                exp_x      = (exp_x < 2047) ? exp_x + 1 : 2047;
                run_active = 1'b1;
                last_x     = int'(pix_x);
            end else if (pix_valid) begin
                run_active = 1'b0;
            end
            if (eol) begin
                eol_cnt++;
                if (last_x != H - 1)
                    lenbad_cnt++;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic apply_word(input logic [20:0] word);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = word;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // One valid sample, optionally preceded by random idle cycles carrying garbage data.
    task automatic put(input logic hs, input logic vs, input logic de);
        for (int g = 0; g < 20; g++) begin
            if (gap_pct == 0 || $urandom_range(99) >= gap_pct)
                break;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 21'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {4'b0000, hs, vs, de, 14'h0000};
    endtask

    task automatic send_line(input int y, input int de_len, input int first_s);
        for (int s = first_s; s < HT; s++)
            put(!(s >= 18 && s < 21), (y < V), (y < V) && (s < de_len));
    endtask

    task automatic send_frame(input int short_y, input int short_len);
        for (int y = 0; y < VT; y++)
            send_line(y, (y == short_y) ? short_len : H, 0);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, e0, x0, l0, s0;

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        check_output("rst_pix_valid", pix_valid, 0);
        check_output("rst_pix_hs", pix_hs, 1);
        check_output("rst_pix_vs", pix_vs, 1);
        check_output("rst_pix_de", pix_de, 0);
        check_output("rst_locked", locked, 0);
        check_output("rst_meas_h_total", meas_h_total, 0);
        check_output("rst_pix_x", pix_x, 0);
        rst = 1'b1;

        // Bit-map vectors
        apply_word(21'h1F8000);
        check_output("w1_pix_valid", pix_valid, 1);
        check_output("w1_b", pix_b, 6'h3C);
        check_output("w1_hs", pix_hs, 1);
        check_output("w1_vs", pix_vs, 1);
        check_output("w1_de", pix_de, 0);
        check_output("w1_rg", {pix_r, pix_g}, 12'h000);
        apply_word(21'h1C0000);
        check_output("w2_b", pix_b, 6'h1C);
        check_output("w2_hsvs", {pix_hs, pix_vs}, 2'b00);
        apply_word(21'h00007E);
        check_output("w3_rgb", {pix_r, pix_g, pix_b}, 18'h3F000);
        apply_word(21'h002001);
        check_output("w4_g", pix_g, 6'h03);
        apply_word(21'h000102);
        check_output("w5_rb", {pix_r, pix_b}, 12'h801);
        apply_word(21'h004000);
        check_output("w6_de", pix_de, 1);

        // Lock acquisition: F0 has no frame start, F1..F3 starts lock at the third
        apply_reset();
        base = sof_cnt;
        send_frame(-1, 0);
        send_frame(-1, 0);
        idle();
        check_output("f1_meas_discarded", meas_h_active, 0);
        e0 = eol_cnt;
        send_frame(-1, 0);
        idle();
        check_output("f2_eol_count", eol_cnt - e0, V);
        check_output("f2_meas_h_active", meas_h_active, H);
        check_output("f2_meas_v_active", meas_v_active, V);
        check_output("f2_meas_h_total", meas_h_total, HT);
        check_output("f2_meas_v_total", meas_v_total, VT);
        send_frame(-1, 0);
        idle();
        check_output("lock_at_sof2", lock_at_sof[base + 1], 0);
        check_output("lock_at_sof3", lock_at_sof[base + 2], 1);
        check_output("f3_locked", locked, 1);

        // Shortened line while locked, then relock after two clean frames
        e0 = err_cnt;
        send_frame(2, H - 1);
        idle();
        check_output("short_locked_drop", locked, 0);
        send_frame(-1, 0);
        send_frame(-1, 0);
        send_frame(-1, 0);
        idle();
        check_output("short_err_pulses", err_cnt - e0, 1);
        check_output("relock_sof5", lock_at_sof[base + 4], 0);
        check_output("relock_sof6", lock_at_sof[base + 5], 0);
        check_output("relock_sof7", lock_at_sof[base + 6], 1);

        // 30% idle gaps
        x0 = xbad_cnt;
        l0 = lenbad_cnt;
        e0 = eol_cnt;
        gap_pct = 30;
        send_frame(-1, 0);
        send_frame(-1, 0);
        gap_pct = 0;
        idle();
        check_output("gap_xseq_bad", xbad_cnt - x0, 0);
        check_output("gap_len_bad", lenbad_cnt - l0, 0);
        check_output("gap_eol_count", eol_cnt - e0, 2 * V);
        check_output("gap_meas", {meas_h_active, meas_v_active, meas_h_total, meas_v_total},
                     {11'd16, 11'd6, 11'd24, 11'd9});
        check_output("gap_locked", locked, 1);

        // Asynchronous reset at pixel (8,3)
        for (int y = 0; y < 3; y++)
            send_line(y, H, 0);
        for (int s = 0; s <= 8; s++)
            put(1'b1, 1'b1, 1'b1);
        idle();
        check_output("pre_rst_pix_x", pix_x, 8);
        check_output("pre_rst_pix_y", pix_y, 3);
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_pix", {pix_valid, pix_de, pix_hs, pix_vs, sof, eol}, 6'b001100);
        check_output("mid_rst_xy", {pix_x, pix_y}, 22'd0);
        check_output("mid_rst_lock", {locked, timing_err}, 2'b00);
        check_output("mid_rst_meas", {meas_h_active, meas_v_active}, 22'd0);
        @(negedge clk);
        rst = 1'b1;
        s0 = sof_cnt;
        send_line(3, H, 9);
        for (int y = 4; y < VT; y++)
            send_line(y, H, 0);
        idle();
        check_output("post_rst_no_sof", sof_cnt - s0, 0);
        send_frame(-1, 0);
        idle();
        check_output("post_rst_sof", sof_cnt - s0, 1);
        check_output("post_rst_meas_discarded", meas_h_active, 0);
        check_output("post_rst_locked", locked, 0);
        send_frame(-1, 0);
        idle();
        check_output("post_rst_meas_h", meas_h_active, H);
        check_output("post_rst_meas_vt", meas_v_total, VT);

        // 3000-sample DE run saturates at 2047
        for (int i = 0; i < 3000; i++)
            put(1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b1, 1'b0);
        idle();
        check_output("long_pix_x_sat", pix_x, 2047);
        for (int i = 0; i < 4; i++)
            put(1'b1, 1'b0, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        idle();
        check_output("long_meas_h_active", meas_h_active, 2047);
        check_output("long_meas_v_active", meas_v_active, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
